// File: rtl/seg_button_io.sv
// Front-panel I/O: scans a 2-digit hex display register onto a common-anode
// 7-segment display and debounces two active-low push-buttons.
module seg_button_io #(
  parameter int SCAN_DIV        = 20000,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_we,
  input  logic [10:0] disp_wdata,
  output logic [10:0] disp_rdata,
  input  logic [1:0]  buttons_i,
  output logic [1:0]  btn_state_o,
  output logic [1:0]  btn_press_o,
  output logic [7:0]  SEG_o,
  output logic [1:0]  COM_o
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  // Active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [10:0]   disp_q, disp_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          digit_q, digit_d;
  logic [7:0]    seg_q, seg_d;
  logic [1:0]    com_q, com_d;
  logic [3:0]    nib;
  logic          dp;

  always_comb begin
    disp_d  = disp_we ? disp_wdata : disp_q;
    scan_d  = scan_q + SW'(1);
    digit_d = digit_q;
    if (scan_q == SCAN_LAST) begin
      scan_d  = '0;
      digit_d = ~digit_q;
    end
    nib   = digit_q ? disp_q[7:4] : disp_q[3:0];
    dp    = digit_q ? disp_q[9]   : disp_q[8];
    seg_d = 8'hFF;
    com_d = 2'b11;
    if (disp_q[10]) begin
      seg_d = {~dp, hex7(nib)};
      com_d = digit_q ? 2'b01 : 2'b10;
    end
  end

  logic [1:0]    sync1_q, sync2_q, stable_q, stable_d, press_q, press_d, s;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];

  assign s = ~sync2_q;

  // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    press_d  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = s[i];
          press_d[i]  = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q   <= 11'h400;
      scan_q   <= '0;
      digit_q  <= 1'b0;
      seg_q    <= 8'hFF;
      com_q    <= 2'b11;
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      stable_q <= 2'b00;
      press_q  <= 2'b00;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      disp_q   <= disp_d;
      scan_q   <= scan_d;
      digit_q  <= digit_d;
      seg_q    <= seg_d;
      com_q    <= com_d;
      sync1_q  <= buttons_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign disp_rdata  = disp_q;
  assign SEG_o       = seg_q;
  assign COM_o       = com_q;
  assign btn_state_o = stable_q;
  assign btn_press_o = press_q;

endmodule

// File: tb/tb_seg_button_io.sv
// Bench for seg_button_io: directed literal checks plus randomized stimulus
// compared every cycle against a behavioural model.
module tb_seg_button_io;
  localparam int SD = 4;
  localparam int DB = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        disp_we = 1'b0;
  logic [10:0] disp_wdata = '0;
  logic [1:0]  buttons_i = 2'b11;
  logic [10:0] disp_rdata;
  logic [1:0]  btn_state_o, btn_press_o, COM_o;
  logic [7:0]  SEG_o;

  seg_button_io #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .disp_we(disp_we), .disp_wdata(disp_wdata),
    .disp_rdata(disp_rdata), .buttons_i(buttons_i), .btn_state_o(btn_state_o),
    .btn_press_o(btn_press_o), .SEG_o(SEG_o), .COM_o(COM_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: digit from edges since reset, debounce from a window of samples.
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [10:0] m_disp = 11'h400;
  logic [7:0]  m_seg = 8'hFF;
  logic [1:0]  m_com = 2'b11, m_state = 2'b00, m_press = 2'b00;
  int          m_edges = 0;
  bit          m_valid = 0;
  logic [1:0]  pin_hist [$];
  logic [1:0]  sw [$];

  always @(posedge clk) begin
    logic [1:0] s_now;
    int         digit;
    logic [3:0] val;
    logic       dp;
    bit         all_flip;
    m_valid = 1;
    if (reset) begin
      m_disp = 11'h400; m_seg = 8'hFF; m_com = 2'b11;
      m_state = 2'b00; m_press = 2'b00; m_edges = 0;
      pin_hist = '{2'b11, 2'b11};
      sw.delete();
    end else begin
      digit = (m_edges / SD) % 2;
      val   = (digit == 1) ? m_disp[7:4] : m_disp[3:0];
      dp    = (digit == 1) ? m_disp[9] : m_disp[8];
      if (m_disp[10]) begin
        m_seg = {~dp, hex_tab[val][6:0]};
        m_com = (digit == 1) ? 2'b01 : 2'b10;
      end else begin
        m_seg = 8'hFF;
        m_com = 2'b11;
      end
      m_edges++;
      if (disp_we) m_disp = disp_wdata;
      s_now = ~pin_hist[0];
      pin_hist.push_back(buttons_i);
      void'(pin_hist.pop_front());
      sw.push_back(s_now);
      if (sw.size() > DB) void'(sw.pop_front());
      m_press = 2'b00;
      for (int i = 0; i < 2; i++) begin
        all_flip = (sw.size() == DB);
        foreach (sw[j]) if (sw[j][i] == m_state[i]) all_flip = 0;
        if (all_flip) begin
          m_state[i] = ~m_state[i];
          m_press[i] = m_state[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("rdata", 32'(disp_rdata), 32'(m_disp));
      check("seg", 32'(SEG_o), 32'(m_seg));
      check("com", 32'(COM_o), 32'(m_com));
      check("com_overlap", 32'(COM_o == 2'b00), 32'd0);
      check("btn_state", 32'(btn_state_o), 32'(m_state));
      check("btn_press", 32'(btn_press_o), 32'(m_press));
    end
  end

  task automatic write_disp(input logic [10:0] v);
    @(negedge clk);
    disp_we = 1'b1;
    disp_wdata = v;
    @(negedge clk);
    disp_we = 1'b0;
  endtask

  // Counts edges (first edge after the call = 0) until btn_state_o[b] == lvl, and press pulses.
  task automatic watch(input int b, input logic lvl, input int len, output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      if (btn_press_o[b]) pulses++;
      if (lat < 0 && btn_state_o[b] == lvl) lat = c;
    end
  endtask

  initial begin
    int n_a, n_b, lat, pulses;
    logic [1:0] first_press;

    repeat (3) @(negedge clk);
    check("rst_seg", 32'(SEG_o), 32'hFF);
    check("rst_com", 32'(COM_o), 32'h3);
    check("rst_state", 32'(btn_state_o), 32'h0);
    check("rst_press", 32'(btn_press_o), 32'h0);
    check("rst_rdata", 32'(disp_rdata), 32'h400);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_com", 32'(COM_o), 32'h2);
    check("rel_seg", 32'(SEG_o), 32'hC0);

    write_disp(11'h6A3);
    n_a = 0; n_b = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (SEG_o == 8'hB0 && COM_o == 2'b10) n_a++;
      if (SEG_o == 8'h08 && COM_o == 2'b01) n_b++;
    end
    check("scan_digit0", 32'(n_a), 32'd8);
    check("scan_digit1", 32'(n_b), 32'd8);

    write_disp(11'h0FF);
    n_a = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (SEG_o == 8'hFF && COM_o == 2'b11) n_a++;
    end
    check("disabled", 32'(n_a), 32'd20);
    write_disp(11'h4FF);
    n_a = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (SEG_o == 8'h8E) n_a++;
    end
    check("hex_F", 32'(n_a), 32'd8);

    @(negedge clk); buttons_i[0] = 1'b0;
    watch(0, 1'b1, 20, lat, pulses);
    check("press_latency", 32'(lat), 32'd6);
    check("press_pulses", 32'(pulses), 32'd1);
    @(negedge clk); buttons_i[0] = 1'b1;
    watch(0, 1'b0, 20, lat, pulses);
    check("release_latency", 32'(lat), 32'd6);
    check("release_pulses", 32'(pulses), 32'd0);

    @(negedge clk); buttons_i[0] = 1'b0;
    repeat (3) @(negedge clk); buttons_i[0] = 1'b1;
    @(negedge clk); buttons_i[0] = 1'b0;
    watch(0, 1'b1, 20, lat, pulses);
    check("bounce_latency", 32'(lat), 32'd6);
    check("bounce_pulses", 32'(pulses), 32'd1);
    @(negedge clk); buttons_i[0] = 1'b1;
    repeat (12) @(negedge clk);

    buttons_i[1] = 1'b0;
    repeat (4) @(negedge clk); buttons_i[1] = 1'b1;
    watch(1, 1'b1, 20, lat, pulses);
    check("glitch_ignored", 32'(lat), 32'hFFFF_FFFF);
    check("glitch_pulses", 32'(pulses), 32'd0);

    @(negedge clk); buttons_i = 2'b00;
    first_press = 2'b00;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (first_press == 2'b00) first_press = btn_press_o;
    end
    check("simultaneous", 32'(first_press), 32'h3);
    @(negedge clk); buttons_i = 2'b11;
    repeat (12) @(negedge clk);

    buttons_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_press", 32'(btn_press_o), 32'h0);
    check("midreset_state", 32'(btn_state_o), 32'h0);
    @(negedge clk); reset = 1'b0;
    watch(0, 1'b1, 20, lat, pulses);
    check("held_reaccept", 32'(pulses), 32'd1);
    check("held_state", 32'(btn_state_o[0]), 32'd1);
    @(negedge clk); buttons_i[0] = 1'b1;
    repeat (12) @(negedge clk);

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      disp_we = ($urandom_range(0, 19) == 0);
      disp_wdata = 11'($urandom);
      if ($urandom_range(0, 3) != 0) disp_wdata[10] = 1'b1;
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 5) == 0) buttons_i[i] = ~buttons_i[i];
    end
    @(negedge clk);
    reset = 1'b0;
    disp_we = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
